grid_scan_gen: RTL and testbench

//  Producer side of the cell-coordinate interface feeding the game-update tick generator and renderer.
//  On each start pulse (frame sync), sweeps the GRID_W x GRID_H cell grid in raster order.

---
 rtl/grid_scan_pkg.sv | 28 ++
 rtl/grid_cell_counter.sv | 62 ++++++
 rtl/grid_scan_gen.sv | 148 ++++++++++++++
 tb/tb_grid_scan_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | grid_scan_pkg : shared grid geometry, park value and scan state encoding.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package grid_scan_pkg;

  localparam int c_grid_w   = 40;
  localparam int c_grid_h   = 30;
  localparam int c_coord_w  = 10;
  localparam int c_park_val = 1023;

  // Last cell of a frame, used by downstream coordinate-match logic.
  localparam int c_last_x = c_grid_w - 1;
  localparam int c_last_y = c_grid_h - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic int cell_count(input int w, input int h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_cell_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | grid_cell_counter : 2-D raster counter, x wraps into y, both wrap to (0,0). |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module grid_cell_counter
  import grid_scan_pkg::*;
#(
  parameter int GRID_W  = c_grid_w,
  parameter int GRID_H  = c_grid_h,
  parameter int COORD_W = c_coord_w
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  localparam logic [COORD_W-1:0] c_max_x = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] c_max_y = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] c_one   = COORD_W'(1);

  logic [COORD_W-1:0] cx_q;
  logic [COORD_W-1:0] cx_d;
  logic [COORD_W-1:0] cy_q;
  logic [COORD_W-1:0] cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr) begin
      cx_d = '0;
      cy_d = '0;
    end else if (inc) begin
      if (cx_q == c_max_x) begin
        cx_d = '0;
        cy_d = (cy_q == c_max_y) ? '0 : cy_q + c_one;
      end else begin
        cx_d = cx_q + c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == c_max_x) && (cy_q == c_max_y);

endmodule
`default_nettype wire

// File: rtl/grid_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | grid_scan_gen : per-frame raster sweep, one registered cell per clock.      |
// | Option SCAN_AUTO_RESTART_EN: frames repeat back to back after first start.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module grid_scan_gen
  import grid_scan_pkg::*;
#(
  parameter int GRID_W   = c_grid_w,
  parameter int GRID_H   = c_grid_h,
  parameter int COORD_W  = c_coord_w,
  parameter int PARK_VAL = c_park_val
) (
  input  logic               in_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               cell_valid,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  localparam logic [COORD_W-1:0] c_park = COORD_W'(PARK_VAL);

  if ((GRID_W >= PARK_VAL) || (GRID_H >= PARK_VAL)) begin : g_bad_grid
    $error("grid_scan_gen: GRID_W and GRID_H must be below PARK_VAL");
  end

  if (PARK_VAL >= (1 << COORD_W)) begin : g_bad_park
    $error("grid_scan_gen: PARK_VAL does not fit in COORD_W bits");
  end

  scan_state_e        state_q;
  scan_state_e        state_d;
  logic [COORD_W-1:0] x_out_q;
  logic [COORD_W-1:0] x_out_d;
  logic [COORD_W-1:0] y_out_q;
  logic [COORD_W-1:0] y_out_d;
  logic               cell_valid_q;
  logic               cell_valid_d;
  logic               frame_done_q;
  logic               frame_done_d;
  logic               busy_q;
  logic               busy_d;
  logic               overrun_q;
  logic               overrun_d;

  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;
  logic               w_last;

  grid_cell_counter #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .COORD_W (COORD_W)
  ) u_cell_counter (
    .clk  (in_clk),
    .rst  (rst),
    .clr  (w_cnt_clr),
    .inc  (w_cnt_inc),
    .cx   (w_cx),
    .cy   (w_cy),
    .last (w_last)
  );

  always_comb begin
    state_d      = state_q;
    x_out_d      = c_park;
    y_out_d      = c_park;
    cell_valid_d = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          w_cnt_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        if (start) begin
          overrun_d = 1'b1;
        end
        // A paused edge neither issues nor advances, so no cell is lost or repeated.
        if (!pause) begin
          x_out_d      = w_cx;
          y_out_d      = w_cy;
          cell_valid_d = 1'b1;
          w_cnt_inc    = 1'b1;
          if (w_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
`ifdef SCAN_AUTO_RESTART_EN
        state_d = ST_SCAN;
`else
        state_d = start ? ST_SCAN : ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_out_q      <= c_park;
      y_out_q      <= c_park;
      cell_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      cell_valid_q <= cell_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign cell_valid = cell_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_grid_scan_gen : randomized stimulus, cell-index reference model, monitor.|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_grid_scan_gen;
  import grid_scan_pkg::*;

  localparam int W      = c_grid_w;
  localparam int H      = c_grid_h;
  localparam int CW     = c_coord_w;
  localparam int PARK   = c_park_val;
  localparam int NCELLS = W * H;

  logic          in_clk = 1'b0;
  logic          rst    = 1'b0;
  logic          start  = 1'b0;
  logic          pause  = 1'b0;
  logic [CW-1:0] x_out;
  logic [CW-1:0] y_out;
  logic          cell_valid;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  always #5 in_clk = ~in_clk;

  grid_scan_gen dut (
    .in_clk     (in_clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .x_out      (x_out),
    .y_out      (y_out),
    .cell_valid (cell_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Reference model: a frame is a sequence of NCELLS raster indices.
  typedef enum {P_IDLE, P_SCAN, P_DONE} phase_t;
  phase_t phase = P_IDLE;
  int     n          = 0;
  int     cyc        = 0;
  int     frames_exp = 0;
  bit     rst_edge   = 1'b0;
  bit     exp_overrun = 1'b0;
  bit     exp_busy   = 1'b0;
  int     cell_q[$];

  int errors = 0;
  int checks = 0;

  int valid_cnt = 0;
  int done_cnt  = 0;
  int match_cnt = 0;
  int last_cyc  = 0;
  int first_cyc = 0;
  int done_cyc  = 0;
  bit prev_last = 1'b0;
  int idx;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step(input bit r, input bit s, input bit p);
    rst   = r;
    start = s;
    pause = p;
    @(posedge in_clk);
    cyc++;
    rst_edge = r;
    if (r) begin
      phase       = P_IDLE;
      n           = 0;
      exp_overrun = 1'b0;
    end else begin
      case (phase)
        P_IDLE: if (s) begin phase = P_SCAN; n = 0; end
        P_SCAN: begin
          if (s) exp_overrun = 1'b1;
          if (!p) begin
            cell_q.push_back(n);
            n++;
            if (n == NCELLS) phase = P_DONE;
          end
        end
        default: begin
          frames_exp++;
          n = 0;
`ifdef SCAN_AUTO_RESTART_EN
          phase = P_SCAN;
`else
          phase = s ? P_SCAN : P_IDLE;
`endif
        end
      endcase
    end
    exp_busy = (phase != P_IDLE);
    #1;
  endtask

  always @(negedge in_clk) begin
    if (cyc > 0) begin
      if (cell_valid === 1'b1) begin
        valid_cnt++;
        if (cell_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cell: got (%0d,%0d) expected no valid cell", x_out, y_out);
        end else begin
          idx = cell_q.pop_front();
          chk("x_out", x_out, idx % W);
          chk("y_out", y_out, idx / W);
        end
        if (x_out == CW'(W - 1) && y_out == CW'(H - 1)) begin
          match_cnt++;
          last_cyc = cyc;
        end
        if (x_out == '0 && y_out == '0) first_cyc = cyc;
      end else begin
        chk("x_park", x_out, PARK);
        chk("y_park", y_out, PARK);
      end
      chk("cell_missing", cell_q.size(), 0);
      if (rst_edge) chk("valid_in_reset", cell_valid, 0);
      chk("frame_done", frame_done, prev_last && !rst_edge);
      chk("busy", busy, exp_busy);
      chk("overrun", overrun, exp_overrun);
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_last = !rst_edge && (cell_valid === 1'b1) &&
                  (x_out == CW'(W - 1)) && (y_out == CW'(H - 1));
    end
  end

  // Drives one SCAN frame to its DONE edge; the DONE edge carries done_start.
  task automatic run_frame(input int pause_at, input int pause_len, input int restart_at,
                           input bit rand_en, input bit done_start);
    int  paused;
    bit  restarted;
    bit  s;
    bit  p;
    paused    = 0;
    restarted = 1'b0;
    for (int g = 0; g < 4 * NCELLS && phase == P_SCAN; g++) begin
      p = rand_en && (n > 0) && ($urandom_range(0, 9) == 0);
      s = rand_en && ($urandom_range(0, 299) == 0);
      if (n == pause_at && paused < pause_len) begin
        p = 1'b1;
        paused++;
      end
      if (n == restart_at && !restarted) begin
        s = 1'b1;
        restarted = 1'b1;
      end
      step(1'b0, s, p);
    end
    if (phase != P_DONE) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got phase %0d expected DONE", phase);
    end
    step(1'b0, done_start, 1'b0);
    @(negedge in_clk);
    #1;
  endtask

  int start_cyc;
  int v0;
  int d0;
  int m0;
  int prev_last_cyc;

  initial begin
    // 1: reset and idle, pause has no effect in IDLE
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

    // 2: plain frame and its latency
    step(1'b0, 1'b1, 1'b0);
    start_cyc = cyc;
    v0 = valid_cnt;
    run_frame(-1, 0, -1, 1'b0, 1'b0);
    chk("t2_valid_count", valid_cnt - v0, NCELLS);
    chk("t2_last_latency", last_cyc - start_cyc, NCELLS);
    chk("t2_done_latency", done_cyc - start_cyc, NCELLS + 1);
    step(1'b1, 1'b0, 1'b0);

    // 3: five paused cycles after cell (10,3)
    step(1'b0, 1'b1, 1'b0);
    start_cyc = cyc;
    v0 = valid_cnt;
    run_frame(3 * W + 11, 5, -1, 1'b0, 1'b0);
    chk("t3_valid_count", valid_cnt - v0, NCELLS);
    chk("t3_done_latency", done_cyc - start_cyc, NCELLS + 6);
    step(1'b1, 1'b0, 1'b0);

    // 4: start inside SCAN sets overrun; start during DONE chains a frame
    step(1'b0, 1'b1, 1'b0);
    run_frame(-1, 0, 15 * W + 20, 1'b0, 1'b1);
    chk("t4_overrun_set", overrun, 1);
    v0 = valid_cnt;
    prev_last_cyc = last_cyc;
    run_frame(-1, 0, -1, 1'b0, 1'b0);
    chk("t4_chain_count", valid_cnt - v0, NCELLS);
    chk("t4_chain_gap", first_cyc - prev_last_cyc, 2);
    chk("t4_overrun_kept", overrun, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_overrun_cleared", overrun, 0);

    // 5: reset at cell (5,5) aborts without frame_done
    step(1'b0, 1'b1, 1'b0);
    d0 = done_cnt;
    while (n < 5 * W + 6) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("t5_no_done", done_cnt - d0, 0);
    step(1'b0, 1'b1, 1'b0);
    v0 = valid_cnt;
    run_frame(-1, 0, -1, 1'b1, 1'b0);
    chk("t5_restart_count", valid_cnt - v0, NCELLS);
    step(1'b1, 1'b0, 1'b0);

    // 6: four randomized frames into a (39,29) match counter
    m0 = match_cnt;
    step(1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      prev_last_cyc = last_cyc;
`ifdef SCAN_AUTO_RESTART_EN
      run_frame(-1, 0, -1, 1'b1, 1'b0);
`else
      run_frame(-1, 0, -1, 1'b1, (f < 3));
`endif
      if (f > 0) chk("t6_frame_gap", first_cyc - prev_last_cyc, 2);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_match_count", match_cnt - m0, 4);
    chk("done_total", done_cnt, frames_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
